// File: rtl/alu_md_ctrl.sv
// alu_md_ctrl -- execute-stage ALU control plus multi-cycle multiply/divide unit.
//
// Decodes aluop/funct into a 4-bit alucontrol. Runs mult/multu/div/divu as
// WIDTH-step shift-add / restoring-divide sequences that write HI/LO. Also
// handles mthi/mtlo writes.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   en                execute-stage instruction valid
//   flush             squash the execute-stage instruction / abort mul-div
//   aluop, funct      main-decoder op class and R-type funct field
//   srca, srcb        operands (rs, rt)
//   alucontrol        ALU operation select (combinational)
//   stall             hold the pipeline while a mul/div issues or computes
//   mf_data           HI for mfhi, otherwise LO
//   hi, lo            current HI/LO contents
module alu_md_ctrl #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] HILO_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [3:0]       alucontrol,
    output logic             stall,
    output logic [WIDTH-1:0] mf_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // Operation captured at issue; signs are kept so the magnitude engine can
    // be fixed up once in DONE.
    typedef struct packed {
        logic is_div;
        logic neg_q;   // negate quotient / product
        logic neg_r;   // negate remainder
        logic dz;      // divide by zero
    } md_req_t;

    state_t           state, state_nxt;
    md_req_t          req;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] oper;            // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc_hi, acc_lo;  // product halves / remainder,quotient
    logic [WIDTH-1:0] hi_r, lo_r;

    // ---------------------------------------------------------------- decode
    always_comb begin
        alucontrol = 4'b0000;
        case (aluop)
            2'b00: alucontrol = 4'b0010;
            2'b01: alucontrol = 4'b0110;
            2'b11: alucontrol = 4'b0001;
            default: begin
                case (funct)
                    6'b100000, 6'b100001: alucontrol = 4'b0010;
                    6'b100010, 6'b100011: alucontrol = 4'b0110;
                    6'b100100:            alucontrol = 4'b0000;
                    6'b100101:            alucontrol = 4'b0001;
                    6'b100110:            alucontrol = 4'b0011;
                    6'b100111:            alucontrol = 4'b0100;
                    6'b101010:            alucontrol = 4'b0111;
                    6'b101011:            alucontrol = 4'b1000;
                    6'b000000:            alucontrol = 4'b1001;
                    6'b000010:            alucontrol = 4'b1010;
                    6'b000011:            alucontrol = 4'b1011;
                    default:              alucontrol = 4'b0000;
                endcase
            end
        endcase
    end

    logic is_r, md_op, mt_op, md_go, signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign is_r      = en && (aluop == 2'b10);
    assign md_op     = is_r && (funct[5:2] == 4'b0110);
    assign mt_op     = is_r && (funct == 6'b010001 || funct == 6'b010011);
    assign md_go     = (state == IDLE) && md_op && !flush;
    assign signed_op = ~funct[0];      // mult/div even, multu/divu odd
    assign a_neg     = signed_op & srca[WIDTH-1];
    assign b_neg     = signed_op & srcb[WIDTH-1];
    assign a_mag     = a_neg ? -srca : srca;
    assign b_mag     = b_neg ? -srcb : srcb;

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (md_op && !flush) begin
                    stall     = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                stall = 1'b1;
                if (flush)         state_nxt = IDLE;
                else if (cnt == 0) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------- iteration step
    logic [WIDTH:0]   mul_sum, div_sh;
    logic [WIDTH-1:0] div_tr, step_hi, step_lo;
    logic             div_ge;

    always_comb begin
        // Multiply: add multiplicand when LSB of multiplier is set, then shift
        // the {carry,acc_hi,acc_lo} right one place.
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, oper} : '0);
        // Restoring divide: shift the next dividend bit into the remainder and
        // subtract the divisor when it fits. A fitting difference is always
        // below the divisor, so the WIDTH-bit modular subtract is exact.
        div_sh  = {acc_hi, acc_lo[WIDTH-1]};
        div_ge  = div_sh >= {1'b0, oper};
        div_tr  = div_sh[WIDTH-1:0] - oper;
        if (req.is_div) begin
            step_hi = div_ge ? div_tr : div_sh[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // ------------------------------------------------------------ sign fixup
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;

    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = req.neg_q ? -prod : prod;
        if (req.is_div) begin
            // Divide by zero leaves the dividend magnitude in acc_hi; with the
            // dividend-sign fix that reproduces srca exactly.
            res_lo = req.dz ? '1 : (req.neg_q ? -acc_lo : acc_lo);
            res_hi = req.neg_r ? -acc_hi : acc_hi;
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r   <= HILO_INIT;
            lo_r   <= HILO_INIT;
            cnt    <= '0;
            req    <= '0;
            oper   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (md_go) begin
                        req.is_div <= funct[1];
                        req.dz     <= funct[1] && (srcb == '0);
                        req.neg_q  <= (a_neg ^ b_neg) && !(funct[1] && (srcb == '0));
                        req.neg_r  <= a_neg;
                        cnt        <= CW'(WIDTH - 1);
                        acc_hi     <= '0;
                        oper       <= funct[1] ? b_mag : a_mag;
                        acc_lo     <= funct[1] ? a_mag : b_mag;
                    end else if (mt_op && !flush) begin
                        // A squashed mthi/mtlo must not update architectural state.
                        if (funct[1]) lo_r <= srca;
                        else          hi_r <= srca;
                    end
                end
                CALC: begin
                    cnt    <= cnt - 1'b1;
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                end
                DONE: begin
                    if (!flush) begin
                        hi_r <= res_hi;
                        lo_r <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi      = hi_r;
    assign lo      = lo_r;
    assign mf_data = (funct == 6'b010000) ? hi_r : lo_r;

endmodule

// File: tb/tb_alu_md_ctrl.sv
module tb_alu_md_ctrl;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, flush;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] srca, srcb, mf_data, hi, lo;
    logic [3:0]  alucontrol;
    logic        stall;

    logic        en8;
    logic [1:0]  aluop8;
    logic [5:0]  funct8;
    logic [7:0]  srca8, srcb8, mf8, hi8, lo8;
    logic [3:0]  alucontrol8;
    logic        stall8;

    alu_md_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .aluop(aluop), .funct(funct),
        .srca(srca), .srcb(srcb), .alucontrol(alucontrol), .stall(stall),
        .mf_data(mf_data), .hi(hi), .lo(lo)
    );

    alu_md_ctrl #(.WIDTH(8), .HILO_INIT(8'hA5)) dut8 (
        .clk(clk), .rst(rst), .en(en8), .flush(flush), .aluop(aluop8), .funct(funct8),
        .srca(srca8), .srcb(srcb8), .alucontrol(alucontrol8), .stall(stall8),
        .mf_data(mf8), .hi(hi8), .lo(lo8)
    );

    int nchk = 0, nerr = 0;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } sb_t;
    sb_t sbq[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Reference {HI,LO} from language arithmetic.
    function automatic logic [63:0] md_model(input logic [5:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] r;
        longint      sa, sb, q, rm;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (f)
            6'b011000: r = sa * sb;
            6'b011001: r = {32'b0, a} * {32'b0, b};
            6'b011010: begin
                if (b == 32'd0)                             r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == '1)     r = {32'h0, 32'h8000_0000};
                else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = {rm[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else            r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b);
        int  n;
        sb_t e;
        sbq.push_back('{tag, md_model(f, a, b)});
        @(posedge clk); #1;
        en = 1'b1; aluop = 2'b10; funct = f; srca = a; srcb = b;
        #1 n = stall ? 1 : 0;
        @(posedge clk); #1;
        en = 1'b0;
        while (stall && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        chk({tag, " stall cycles"}, 64'(n), 64'd33);
        @(posedge clk); #1;
        e = sbq.pop_front();
        chk(e.tag, {hi, lo}, e.exp);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] exp;
    } ac_t;

    ac_t actab[11] = '{
        '{2'b00, 6'b000000, 4'h2}, '{2'b01, 6'b000000, 4'h6}, '{2'b11, 6'b000000, 4'h1},
        '{2'b10, 6'b100111, 4'h4}, '{2'b10, 6'b111111, 4'h0}, '{2'b10, 6'b101011, 4'h8},
        '{2'b10, 6'b000011, 4'hB}, '{2'b10, 6'b100110, 4'h3}, '{2'b10, 6'b101010, 4'h7},
        '{2'b10, 6'b000010, 4'hA}, '{2'b10, 6'b100011, 4'h6}
    };

    initial begin
        int  n;
        sb_t e;
        rst = 1'b1; en = 1'b0; flush = 1'b0; aluop = 2'b00; funct = '0; srca = '0; srcb = '0;
        en8 = 1'b0; aluop8 = 2'b00; funct8 = '0; srca8 = '0; srcb8 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst stall", 64'(stall), 64'd0);
        chk("rst hilo", {hi, lo}, 64'd0);
        chk("rst hilo8", {48'b0, hi8, lo8}, 64'hA5A5);

        // Decode table, en low so no side effects.
        foreach (actab[i]) begin
            aluop = actab[i].op; funct = actab[i].f;
            #1 chk($sformatf("aluctl %0d", i), 64'(alucontrol), 64'(actab[i].exp));
        end

        // en low or flush in IDLE must not start a mul/div.
        aluop = 2'b10; funct = 6'b011000; en = 1'b0;
        #1 chk("en low stall", 64'(stall), 64'd0);
        en = 1'b1; flush = 1'b1;
        #1 chk("flush idle stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        en = 1'b0; flush = 1'b0;
        #1 chk("flush idle no start", 64'(stall), 64'd0);

        run_md("mult -3*7",   6'b011000, 32'hFFFF_FFFD, 32'd7);
        run_md("divu 100/7",  6'b011011, 32'd100, 32'd7);
        run_md("div -7/2",    6'b011010, 32'hFFFF_FFF9, 32'd2);
        run_md("div 5/0",     6'b011010, 32'd5, 32'd0);
        run_md("div min/-1",  6'b011010, 32'h8000_0000, 32'hFFFF_FFFF);
        run_md("multu max",   6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_md("div -9/0",    6'b011010, 32'hFFFF_FFF7, 32'd0);
        for (int i = 0; i < 6; i++)
            run_md($sformatf("rand %0d", i), 6'b011000 | 6'($urandom_range(0, 3)),
                   $urandom, (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom);

        // mthi / mtlo then mfhi / mflo.
        @(posedge clk); #1;
        en = 1'b1; aluop = 2'b10; funct = 6'b010001; srca = 32'h1234;
        @(posedge clk); #1;
        funct = 6'b010011; srca = 32'h5678;
        @(posedge clk); #1;
        en = 1'b0; funct = 6'b010000;
        #1 chk("mfhi", 64'(mf_data), 64'h1234);
        funct = 6'b010010;
        #1 chk("mflo", 64'(mf_data), 64'h5678);

        // Flush at CALC cycle 10 aborts without touching HI/LO.
        @(posedge clk); #1;
        en = 1'b1; funct = 6'b011000; srca = 32'd3; srcb = 32'd3;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush stall", 64'(stall), 64'd0);
        chk("flush hilo", {hi, lo}, 64'h0000_1234_0000_5678);
        repeat (36) @(posedge clk);
        #1 chk("flush hilo later", {hi, lo}, 64'h0000_1234_0000_5678);

        // Reset in the middle of CALC.
        @(posedge clk); #1;
        en = 1'b1; funct = 6'b011000; srca = 32'hFFFF_FFFD; srcb = 32'd7;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst stall", 64'(stall), 64'd0);
        chk("midrst hilo", {hi, lo}, 64'd0);
        @(posedge clk); #1;
        chk("midrst stall later", 64'(stall), 64'd0);

        // WIDTH=8 multiply: -3*7.
        sbq.push_back('{"mult8 -3*7", 64'h0000_0000_0000_FFEB});
        @(posedge clk); #1;
        en8 = 1'b1; aluop8 = 2'b10; funct8 = 6'b011000; srca8 = 8'hFD; srcb8 = 8'd7;
        #1 n = stall8 ? 1 : 0;
        @(posedge clk); #1;
        en8 = 1'b0;
        while (stall8 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk("mult8 stall cycles", 64'(n), 64'd9);
        @(posedge clk); #1;
        e = sbq.pop_front();
        chk(e.tag, {48'b0, hi8, lo8}, e.exp);

        run_md("after rst div", 6'b011010, 32'd17, 32'hFFFF_FFFB);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
